// File: rtl/riscv_ctrl_pkg.sv
// Shared control-bundle types, opcode/ALUOp/forward-select encodings and small helpers
// for the ID->EX->MEM->WB control pipeline.
package riscv_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 2;
  localparam int unsigned FWD_W      = 2;
  localparam int unsigned OPC_W      = 7;

  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;

  localparam logic [ALUOP_W-1:0] ALUOP_MEM    = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_ARITH  = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_LUI    = 2'b11;

  localparam logic [FWD_W-1:0] FWD_NONE = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM  = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB   = 2'b01;

  typedef struct packed {
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic               branch;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               regwrite;
  } ctrl_t;

  typedef struct packed {
    logic                  valid;
    ctrl_t                 ctrl;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } stage_t;

  // Register-immediate ALU ops ignore rs2; stores and branches still read it.
  function automatic logic uses_rs2(input ctrl_t c);
    return !c.alusrc | c.memwrite | c.branch;
  endfunction

  function automatic ctrl_t decode(input logic [OPC_W-1:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OPC_RTYPE:  begin c.aluop = ALUOP_ARITH; c.regwrite = 1'b1; end
      OPC_ITYPE:  begin c.alusrc = 1'b1; c.aluop = ALUOP_ARITH; c.regwrite = 1'b1; end
      OPC_LOAD:   begin
        c.alusrc = 1'b1; c.aluop = ALUOP_MEM; c.memread = 1'b1;
        c.memtoreg = 1'b1; c.regwrite = 1'b1;
      end
      OPC_STORE:  begin c.alusrc = 1'b1; c.aluop = ALUOP_MEM; c.memwrite = 1'b1; end
      OPC_BRANCH: begin c.aluop = ALUOP_BRANCH; c.branch = 1'b1; end
      OPC_LUI:    begin c.alusrc = 1'b1; c.aluop = ALUOP_LUI; c.regwrite = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Decoder-side inputs and per-stage control outputs of the control pipeline.
interface ctrl_pipeline_if;
  import riscv_ctrl_pkg::*;

  logic                  id_valid;
  logic                  id_alusrc;
  logic                  id_memtoreg;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  id_memwrite;
  logic                  id_branch;
  logic [ALUOP_W-1:0]    id_aluop;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  ex_branch_taken;

  logic                  stall;
  logic                  flush;
  logic                  ex_alusrc;
  logic [ALUOP_W-1:0]    ex_aluop;
  logic                  ex_branch;
  logic                  ex_memread;
  logic                  ex_memwrite;
  logic                  ex_memtoreg;
  logic                  ex_regwrite;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_memread;
  logic                  mem_memwrite;
  logic                  mem_memtoreg;
  logic                  mem_regwrite;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  wb_memtoreg;
  logic                  wb_regwrite;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [FWD_W-1:0]      fwd_a;
  logic [FWD_W-1:0]      fwd_b;

  modport master (
    output id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite,
           id_branch, id_aluop, id_rs1, id_rs2, id_rd, ex_branch_taken,
    input  stall, flush, ex_alusrc, ex_aluop, ex_branch, ex_memread, ex_memwrite,
           ex_memtoreg, ex_regwrite, ex_rd, mem_memread, mem_memwrite, mem_memtoreg,
           mem_regwrite, mem_rd, wb_memtoreg, wb_regwrite, wb_rd, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite,
           id_branch, id_aluop, id_rs1, id_rs2, id_rd, ex_branch_taken,
    output stall, flush, ex_alusrc, ex_aluop, ex_branch, ex_memread, ex_memwrite,
           ex_memtoreg, ex_regwrite, ex_rd, mem_memread, mem_memwrite, mem_memtoreg,
           mem_regwrite, mem_rd, wb_memtoreg, wb_regwrite, wb_rd, fwd_a, fwd_b
  );

endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline register for the control bundle; a bubble or invalid input stores all zeros
// so an empty stage presents inactive controls and rd=0.
module ctrl_stage_reg
  import riscv_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk) begin
    if (reset || bubble || !d.valid) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline from ID to WB with load-use stall, taken-branch flush and
// EX-stage operand forwarding selects.
module ctrl_pipeline
  import riscv_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  ctrl_pipeline_if.slave  bus
);

  stage_t id_s;
  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;

  logic             stall_c;
  logic             flush_c;
  logic [FWD_W-1:0] fwd_a_c;
  logic [FWD_W-1:0] fwd_b_c;
  logic             mem_fwd_ok;
  logic             wb_fwd_ok;
  logic             unused_fields;

  assign id_s = '{
    valid: bus.id_valid,
    ctrl:  '{alusrc:   bus.id_alusrc,
             aluop:    bus.id_aluop,
             branch:   bus.id_branch,
             memread:  bus.id_memread,
             memwrite: bus.id_memwrite,
             memtoreg: bus.id_memtoreg,
             regwrite: bus.id_regwrite},
    rs1:   bus.id_rs1,
    rs2:   bus.id_rs2,
    rd:    bus.id_rd
  };

  // A stage may forward only if it really writes a non-x0 register.
  assign mem_fwd_ok = mem_q.valid & mem_q.ctrl.regwrite & (mem_q.rd != '0);
  assign wb_fwd_ok  = wb_q.valid & wb_q.ctrl.regwrite & (wb_q.rd != '0);

  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  mem_ok,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  wb_ok,
    input logic [REG_ADDR_W-1:0] wb_rd
  );
    if (mem_ok && (mem_rd == rs)) return FWD_MEM;
    if (wb_ok && (wb_rd == rs))   return FWD_WB;
    return FWD_NONE;
  endfunction

  // Hazard and forwarding decisions; flush overrides stall since the ID op is squashed.
  always_comb begin
    stall_c = 1'b0;
    flush_c = 1'b0;
    fwd_a_c = FWD_NONE;
    fwd_b_c = FWD_NONE;
    if (!reset) begin
      flush_c = ex_q.valid & ex_q.ctrl.branch & bus.ex_branch_taken;
      stall_c = bus.id_valid & ex_q.valid & ex_q.ctrl.memread & (ex_q.rd != '0) &
                ((ex_q.rd == id_s.rs1) | (uses_rs2(id_s.ctrl) & (ex_q.rd == id_s.rs2))) &
                !flush_c;
      fwd_a_c = fwd_sel(ex_q.rs1, mem_fwd_ok, mem_q.rd, wb_fwd_ok, wb_q.rd);
      if (uses_rs2(ex_q.ctrl)) begin
        fwd_b_c = fwd_sel(ex_q.rs2, mem_fwd_ok, mem_q.rd, wb_fwd_ok, wb_q.rd);
      end
    end
  end

  ctrl_stage_reg u_ex (
    .clk    (clk),
    .reset  (reset),
    .bubble (stall_c | flush_c),
    .d      (id_s),
    .q      (ex_q)
  );

  ctrl_stage_reg u_mem (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  ctrl_stage_reg u_wb (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  assign bus.stall = stall_c;
  assign bus.flush = flush_c;
  assign bus.fwd_a = fwd_a_c;
  assign bus.fwd_b = fwd_b_c;

  assign bus.ex_alusrc   = ex_q.ctrl.alusrc;
  assign bus.ex_aluop    = ex_q.ctrl.aluop;
  assign bus.ex_branch   = ex_q.ctrl.branch;
  assign bus.ex_memread  = ex_q.ctrl.memread;
  assign bus.ex_memwrite = ex_q.ctrl.memwrite;
  assign bus.ex_memtoreg = ex_q.ctrl.memtoreg;
  assign bus.ex_regwrite = ex_q.ctrl.regwrite;
  assign bus.ex_rd       = ex_q.rd;

  assign bus.mem_memread  = mem_q.ctrl.memread;
  assign bus.mem_memwrite = mem_q.ctrl.memwrite;
  assign bus.mem_memtoreg = mem_q.ctrl.memtoreg;
  assign bus.mem_regwrite = mem_q.ctrl.regwrite;
  assign bus.mem_rd       = mem_q.rd;

  assign bus.wb_memtoreg = wb_q.ctrl.memtoreg;
  assign bus.wb_regwrite = wb_q.ctrl.regwrite;
  assign bus.wb_rd       = wb_q.rd;

  // Fields carried down the pipe that later stages have no consumer for.
  assign unused_fields = ^{mem_q.rs1, mem_q.rs2, mem_q.ctrl.alusrc, mem_q.ctrl.aluop,
                           mem_q.ctrl.branch, wb_q.rs1, wb_q.rs2, wb_q.ctrl.alusrc,
                           wb_q.ctrl.aluop, wb_q.ctrl.branch, wb_q.ctrl.memread,
                           wb_q.ctrl.memwrite};

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed table-driven bench for ctrl_pipeline: per-cycle inputs with hand-computed
// stall/flush/forward selects and stage controls.
module tb_ctrl_pipeline;
  import riscv_ctrl_pkg::*;

  localparam logic [6:0] R = OPC_RTYPE;
  localparam logic [6:0] I = OPC_ITYPE;
  localparam logic [6:0] L = OPC_LOAD;
  localparam logic [6:0] B = OPC_BRANCH;
  localparam int FM = 2;  // forward from MEM (2'b10)
  localparam int FW = 1;  // forward from WB  (2'b01)

  typedef struct {
    logic       rst;
    logic       vld;
    logic [6:0] opc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       tk;
    logic       stall;
    logic       flush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       exw;
    logic [4:0] exrd;
    logic       exmr;
    logic       memw;
    logic [4:0] memrd;
    logic       wbw;
    logic [4:0] wbrd;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  ctrl_pipeline_if bus ();

  ctrl_pipeline dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int rst, input int vld, input logic [6:0] opc, input int rs1,
                     input int rs2, input int rd, input int tk, input int st, input int fl,
                     input int fa, input int fb, input int exw, input int exrd, input int exmr,
                     input int memw, input int memrd, input int wbw, input int wbrd);
    vec_t v;
    v.rst = 1'(rst);   v.vld = 1'(vld);   v.opc = opc;
    v.rs1 = 5'(rs1);   v.rs2 = 5'(rs2);   v.rd = 5'(rd);     v.tk = 1'(tk);
    v.stall = 1'(st);  v.flush = 1'(fl);  v.fa = 2'(fa);     v.fb = 2'(fb);
    v.exw = 1'(exw);   v.exrd = 5'(exrd); v.exmr = 1'(exmr);
    v.memw = 1'(memw); v.memrd = 5'(memrd);
    v.wbw = 1'(wbw);   v.wbrd = 5'(wbrd);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [6:0] opc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic tk);
    ctrl_t c;
    c = vld ? decode(opc) : '0;
    reset               = rst;
    bus.id_valid        = vld;
    bus.id_alusrc       = c.alusrc;
    bus.id_aluop        = c.aluop;
    bus.id_branch       = c.branch;
    bus.id_memread      = c.memread;
    bus.id_memwrite     = c.memwrite;
    bus.id_memtoreg     = c.memtoreg;
    bus.id_regwrite     = c.regwrite;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    bus.id_rd           = rd;
    bus.ex_branch_taken = tk;
  endtask

  logic [29:0] all_regs;
  assign all_regs = {bus.ex_alusrc, bus.ex_aluop, bus.ex_branch, bus.ex_memread,
                     bus.ex_memwrite, bus.ex_memtoreg, bus.ex_regwrite, bus.ex_rd,
                     bus.mem_memread, bus.mem_memwrite, bus.mem_memtoreg, bus.mem_regwrite,
                     bus.mem_rd, bus.wb_memtoreg, bus.wb_regwrite, bus.wb_rd};

  initial begin
    checks = 0;
    errors = 0;

    // Row: rst vld opc rs1 rs2 rd tk | stall flush fa fb | exw exrd exmr | memw memrd | wbw wbrd
    add(0,1,R, 1,2,5, 0,  0,0,0,0,   0,0,0,   0,0,   0,0);   // ADD x5 enters ID
    add(0,0,R, 0,0,0, 0,  0,0,0,0,   1,5,0,   0,0,   0,0);
    add(0,0,R, 0,0,0, 0,  0,0,0,0,   0,0,0,   1,5,   0,0);
    add(0,0,R, 0,0,0, 0,  0,0,0,0,   0,0,0,   0,0,   1,5);   // WB three cycles later
    add(0,1,L, 1,0,5, 0,  0,0,0,0,   0,0,0,   0,0,   0,0);   // LW x5
    add(0,1,R, 5,7,6, 0,  1,0,0,0,   1,5,1,   0,0,   0,0);   // ADD x6,x5,x7 stalls
    add(0,1,R, 5,7,6, 0,  0,0,0,0,   0,0,0,   1,5,   0,0);   // held, EX bubble
    add(0,0,R, 0,0,0, 0,  0,0,FW,0,  1,6,0,   0,0,   1,5);   // ADD in EX, rs1 from WB
    add(0,1,L, 1,0,5, 0,  0,0,0,0,   0,0,0,   1,6,   0,0);   // LW x5
    add(0,1,I, 1,5,8, 0,  0,0,0,0,   1,5,1,   0,0,   1,6);   // ADDI rs2 field=5: no stall
    add(0,1,R, 1,2,3, 0,  0,0,0,0,   1,8,0,   1,5,   0,0);   // ADDI rs2 not forwarded
    add(0,1,R, 3,3,4, 0,  0,0,0,0,   1,3,0,   1,8,   1,5);   // SUB x4,x3,x3 behind ADD x3
    add(0,0,R, 0,0,0, 0,  0,0,FM,FM, 1,4,0,   1,3,   1,8);
    add(0,1,R, 1,2,3, 0,  0,0,0,0,   0,0,0,   1,4,   1,3);   // ADD x3, NOP, SUB
    add(0,0,R, 0,0,0, 0,  0,0,0,0,   1,3,0,   0,0,   1,4);
    add(0,1,R, 3,3,4, 0,  0,0,0,0,   0,0,0,   1,3,   0,0);
    add(0,0,R, 0,0,0, 0,  0,0,FW,FW, 1,4,0,   0,0,   1,3);
    add(0,1,R, 1,2,3, 0,  0,0,0,0,   0,0,0,   1,4,   0,0);   // two writers of x3
    add(0,1,R, 3,2,3, 0,  0,0,0,0,   1,3,0,   0,0,   1,4);
    add(0,1,R, 3,3,4, 0,  0,0,FM,0,  1,3,0,   1,3,   0,0);
    add(0,0,R, 0,0,0, 0,  0,0,FM,FM, 1,4,0,   1,3,   1,3);   // MEM beats WB
    add(0,1,B, 1,2,0, 0,  0,0,0,0,   0,0,0,   1,4,   1,3);   // BEQ
    add(0,1,L, 1,0,9, 1,  0,1,0,0,   0,0,0,   0,0,   1,4);   // taken: flush, no stall
    add(0,0,R, 0,0,0, 0,  0,0,0,0,   0,0,0,   0,0,   0,0);   // LW x9 squashed
    add(0,1,B, 1,2,0, 0,  0,0,0,0,   0,0,0,   0,0,   0,0);   // BEQ not taken
    add(0,1,R, 1,2,10,0,  0,0,0,0,   0,0,0,   0,0,   0,0);
    add(0,0,R, 0,0,0, 0,  0,0,0,0,   1,10,0,  0,0,   0,0);
    add(0,1,R, 1,2,0, 0,  0,0,0,0,   0,0,0,   1,10,  0,0);   // ADD x0
    add(0,1,L, 1,0,0, 0,  0,0,0,0,   1,0,0,   0,0,   1,10);  // LW x0
    add(0,1,R, 0,0,11,0,  0,0,0,0,   1,0,1,   1,0,   0,0);   // use of x0: no stall
    add(0,0,R, 0,0,0, 0,  0,0,0,0,   1,11,0,  1,0,   1,0);   // x0 never forwards
    add(0,1,L, 1,0,5, 0,  0,0,0,0,   0,0,0,   1,11,  1,0);   // LW x5 then ADD in flight
    add(0,1,R, 5,7,6, 0,  1,0,0,0,   1,5,1,   0,0,   1,11);
    add(1,1,R, 5,7,6, 0,  0,0,0,0,   0,0,0,   1,5,   0,0);   // reset mid-flight
    add(0,1,R, 5,7,6, 0,  0,0,0,0,   0,0,0,   0,0,   0,0);   // everything dropped
    add(0,0,R, 0,0,0, 0,  0,0,0,0,   1,6,0,   0,0,   0,0);

    // Reset held two cycles with a valid instruction in ID.
    drive(1'b1, 1'b1, R, 5'd1, 5'd2, 5'd5, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst%0d.stall", c), 8'(bus.stall), 8'd0);
      check($sformatf("rst%0d.flush", c), 8'(bus.flush), 8'd0);
      check($sformatf("rst%0d.fwd_a", c), 8'(bus.fwd_a), 8'd0);
      check($sformatf("rst%0d.fwd_b", c), 8'(bus.fwd_b), 8'd0);
      check($sformatf("rst%0d.regs_zero", c), 8'(all_regs != '0), 8'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].rst, vecs[i].vld, vecs[i].opc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].tk);
      @(negedge clk);
      check($sformatf("v%0d.stall", i),        8'(bus.stall),        8'(vecs[i].stall));
      check($sformatf("v%0d.flush", i),        8'(bus.flush),        8'(vecs[i].flush));
      check($sformatf("v%0d.fwd_a", i),        8'(bus.fwd_a),        8'(vecs[i].fa));
      check($sformatf("v%0d.fwd_b", i),        8'(bus.fwd_b),        8'(vecs[i].fb));
      check($sformatf("v%0d.ex_regwrite", i),  8'(bus.ex_regwrite),  8'(vecs[i].exw));
      check($sformatf("v%0d.ex_rd", i),        8'(bus.ex_rd),        8'(vecs[i].exrd));
      check($sformatf("v%0d.ex_memread", i),   8'(bus.ex_memread),   8'(vecs[i].exmr));
      check($sformatf("v%0d.mem_regwrite", i), 8'(bus.mem_regwrite), 8'(vecs[i].memw));
      check($sformatf("v%0d.mem_rd", i),       8'(bus.mem_rd),       8'(vecs[i].memrd));
      check($sformatf("v%0d.wb_regwrite", i),  8'(bus.wb_regwrite),  8'(vecs[i].wbw));
      check($sformatf("v%0d.wb_rd", i),        8'(bus.wb_rd),        8'(vecs[i].wbrd));
    end

    // Load bundle walks to WB with memtoreg intact and nothing else asserted.
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, L, 5'd2, 5'd0, 5'd7, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("ld.ex_bundle", 8'({bus.ex_alusrc, bus.ex_aluop, bus.ex_branch, bus.ex_memread,
                              bus.ex_memwrite, bus.ex_memtoreg, bus.ex_regwrite}),
          8'b1000_1011);
    @(posedge clk);
    @(negedge clk);
    check("ld.mem_bundle", 8'({bus.mem_memread, bus.mem_memwrite, bus.mem_memtoreg,
                               bus.mem_regwrite}), 8'b1011);
    @(posedge clk);
    @(negedge clk);
    check("ld.wb_bundle", 8'({bus.wb_memtoreg, bus.wb_regwrite, bus.wb_rd}),
          8'({1'b1, 1'b1, 5'd7}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
